// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the pipeline hazard controller.
//   fwd_sel_e   : E-stage operand source select (register file / W / M)
//   MUL_LAT_DEF : default multiply occupancy of the MDU, in cycles
//   DIV_LAT_DEF : default divide occupancy of the MDU, in cycles
//   cnt_width() : bits needed for a down-counter that is loaded with max_lat
// -----------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    localparam int MUL_LAT_DEF = 4;
    localparam int DIV_LAT_DEF = 32;

    function automatic int cnt_width(input int max_lat);
        return (max_lat < 1) ? 1 : $clog2(max_lat + 1);
    endfunction

endpackage

// File: rtl/mdu_busy_tracker.sv
// -----------------------------------------------------------------------------
// mdu_busy_tracker
// Tracks how long the multi-cycle multiply/divide unit stays occupied.
// An accepted start loads the latency of the issued operation; the counter
// then counts down to zero. A start while busy simply reloads (restart).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : accepted mult/div issue this cycle
//   is_div     : qualifies start, 1 = divide, 0 = multiply
//   busy       : counter nonzero
// -----------------------------------------------------------------------------
module mdu_busy_tracker
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam int CNT_W = cnt_width((DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = is_div ? DIV_LOAD : MUL_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Combinational from the register so it drops as soon as reset clears it.
    assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Hazard controller for the 5-stage MIPS core: E/D forwarding selects,
// load-use / branch / MDU stalls, data-memory wait freeze of F..M, flushes.
// Inputs : D-stage rs_d/rt_d/branch_d/jump_r_d/mdu_use_d/predict_miss,
//          E-stage rs_e/rt_e/wa_e/we_e/load_e/mdu_start_e/mdu_div_e,
//          M-stage wa_m/we_m/load_m/dmem_ready, W-stage wa_w/we_w.
// Outputs: stall_f/d/e/m, flush_d/e/w, fwd_a_d/fwd_b_d, fwd_a_e/fwd_b_e,
//          mdu_busy.
// Optional: define HAZARD_PERF_EN to build perf_clr and the saturating
//          perf_stall / perf_memwait / perf_flush counters.
// Memory handshake: a load in M holds F..M while dmem_ready is low; the cycle
// dmem_ready is high the pipeline advances with no extra bubble.
// -----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int PERF_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs_d,
    input  logic [REG_AW-1:0] rt_d,
    input  logic              branch_d,
    input  logic              jump_r_d,
    input  logic              mdu_use_d,
    input  logic              predict_miss,
    input  logic [REG_AW-1:0] rs_e,
    input  logic [REG_AW-1:0] rt_e,
    input  logic [REG_AW-1:0] wa_e,
    input  logic              we_e,
    input  logic              load_e,
    input  logic              mdu_start_e,
    input  logic              mdu_div_e,
    input  logic [REG_AW-1:0] wa_m,
    input  logic              we_m,
    input  logic              load_m,
    input  logic              dmem_ready,
    input  logic [REG_AW-1:0] wa_w,
    input  logic              we_w,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              stall_m,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_w,
    output logic              fwd_a_d,
    output logic              fwd_b_d,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
    output logic              mdu_busy
`ifdef HAZARD_PERF_EN
    ,
    input  logic              perf_clr,
    output logic [PERF_W-1:0] perf_stall,
    output logic [PERF_W-1:0] perf_memwait,
    output logic [PERF_W-1:0] perf_flush
`endif
);

    // Register 0 is hard-wired zero, so it never creates a dependency.
    logic rs_d_m, rt_d_m, rs_d_e, rt_d_e;
    assign rs_d_m = (rs_d != '0) && (rs_d == wa_m);
    assign rt_d_m = (rt_d != '0) && (rt_d == wa_m);
    assign rs_d_e = (rs_d != '0) && (rs_d == wa_e);
    assign rt_d_e = (rt_d != '0) && (rt_d == wa_e);

    fwd_sel_e fwd_a_sel, fwd_b_sel;

    always_comb begin
        fwd_a_sel = FWD_RF;
        if (we_m && rs_e != '0 && rs_e == wa_m)      fwd_a_sel = FWD_MEM;
        else if (we_w && rs_e != '0 && rs_e == wa_w) fwd_a_sel = FWD_WB;

        fwd_b_sel = FWD_RF;
        if (we_m && rt_e != '0 && rt_e == wa_m)      fwd_b_sel = FWD_MEM;
        else if (we_w && rt_e != '0 && rt_e == wa_w) fwd_b_sel = FWD_WB;
    end

    assign fwd_a_e = fwd_a_sel;
    assign fwd_b_e = fwd_b_sel;
    assign fwd_a_d = rs_d_m && we_m;
    assign fwd_b_d = rt_d_m && we_m;

    logic mem_stall, lw_stall, br_stall, mdu_stall, hz;
    assign mem_stall = load_m && !dmem_ready;
    assign lw_stall  = load_e && (rs_d_e || rt_d_e);
    assign br_stall  = (branch_d || jump_r_d) &&
                       ((we_e && (rs_d_e || rt_d_e)) || (load_m && (rs_d_m || rt_d_m)));
    // A mult/div sitting in E counts as busy already, before the counter loads.
    assign mdu_stall = mdu_use_d && (mdu_busy || mdu_start_e);
    assign hz        = lw_stall || br_stall || mdu_stall;

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (mem_stall) begin
            // Memory wait freezes everything up to M and suppresses flushes
            // (including predict_miss) until the load completes.
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (hz) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end else begin
            flush_d = predict_miss || jump_r_d;
            flush_e = predict_miss;
        end
    end

    // A start held in a frozen E stage is not accepted; it issues on release.
    mdu_busy_tracker #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_mdu (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mdu_start_e && !stall_e),
        .is_div (mdu_div_e),
        .busy   (mdu_busy)
    );

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] perf_stall_q, perf_memwait_q, perf_flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q   <= '0;
            perf_memwait_q <= '0;
            perf_flush_q   <= '0;
        end else if (perf_clr) begin
            perf_stall_q   <= '0;
            perf_memwait_q <= '0;
            perf_flush_q   <= '0;
        end else begin
            // Saturate at all-ones rather than wrapping.
            if (stall_f && !(&perf_stall_q))
                perf_stall_q <= perf_stall_q + 1'b1;
            if (mem_stall && !(&perf_memwait_q))
                perf_memwait_q <= perf_memwait_q + 1'b1;
            if (predict_miss && !stall_d && !(&perf_flush_q))
                perf_flush_q <= perf_flush_q + 1'b1;
        end
    end

    assign perf_stall   = perf_stall_q;
    assign perf_memwait = perf_memwait_q;
    assign perf_flush   = perf_flush_q;
`else
    localparam int unused_perf_w = PERF_W;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int REG_AW = 5;
    localparam int PERF_W = 32;

    logic clk, rst_n;
    logic [REG_AW-1:0] rs_d, rt_d, rs_e, rt_e, wa_e, wa_m, wa_w;
    logic branch_d, jump_r_d, mdu_use_d, predict_miss;
    logic we_e, load_e, mdu_start_e, mdu_div_e;
    logic we_m, load_m, dmem_ready, we_w;
    logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
    logic fwd_a_d, fwd_b_d, mdu_busy;
    logic [1:0] fwd_a_e, fwd_b_e;
`ifdef HAZARD_PERF_EN
    logic perf_clr;
    logic [PERF_W-1:0] perf_stall, perf_memwait, perf_flush;
`endif

    hazard_ctrl #(
        .REG_AW (REG_AW), .MUL_LAT (4), .DIV_LAT (32), .PERF_W (PERF_W)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .rs_d (rs_d), .rt_d (rt_d), .branch_d (branch_d), .jump_r_d (jump_r_d),
        .mdu_use_d (mdu_use_d), .predict_miss (predict_miss),
        .rs_e (rs_e), .rt_e (rt_e), .wa_e (wa_e), .we_e (we_e), .load_e (load_e),
        .mdu_start_e (mdu_start_e), .mdu_div_e (mdu_div_e),
        .wa_m (wa_m), .we_m (we_m), .load_m (load_m), .dmem_ready (dmem_ready),
        .wa_w (wa_w), .we_w (we_w),
        .stall_f (stall_f), .stall_d (stall_d), .stall_e (stall_e), .stall_m (stall_m),
        .flush_d (flush_d), .flush_e (flush_e), .flush_w (flush_w),
        .fwd_a_d (fwd_a_d), .fwd_b_d (fwd_b_d), .fwd_a_e (fwd_a_e), .fwd_b_e (fwd_b_e),
        .mdu_busy (mdu_busy)
`ifdef HAZARD_PERF_EN
        ,
        .perf_clr (perf_clr), .perf_stall (perf_stall),
        .perf_memwait (perf_memwait), .perf_flush (perf_flush)
`endif
    );

    // Output bundle: {stall_f,d,e,m, flush_d,e,w, fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e, busy}
    logic [13:0] obs;
    assign obs = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
                  fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e, mdu_busy};

    localparam logic [13:0] E_NONE  = 14'h0000;
    localparam logic [13:0] E_MEM   = 14'h3C80;
    localparam logic [13:0] E_HZ    = 14'h3100;
    localparam logic [13:0] E_FL_D  = 14'h0200;
    localparam logic [13:0] E_FL_E  = 14'h0100;
    localparam logic [13:0] E_FAD   = 14'h0040;
    localparam logic [13:0] E_FBD   = 14'h0020;
    localparam logic [13:0] E_FAE_M = 14'h0010;
    localparam logic [13:0] E_FAE_W = 14'h0008;
    localparam logic [13:0] E_FBE_M = 14'h0004;
    localparam logic [13:0] E_FBE_W = 14'h0002;
    localparam logic [13:0] E_BUSY  = 14'h0001;

    logic [13:0] exp_q[$];
    logic [13:0] exp_v;
    int checks = 0;
    int errors = 0;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected summary");
        $fatal(1);
    end

    // driver tasks
    task automatic set_idle();
        rs_d = '0; rt_d = '0; branch_d = 0; jump_r_d = 0; mdu_use_d = 0;
        predict_miss = 0; rs_e = '0; rt_e = '0; wa_e = '0; we_e = 0; load_e = 0;
        mdu_start_e = 0; mdu_div_e = 0; wa_m = '0; we_m = 0; load_m = 0;
        dmem_ready = 1; wa_w = '0; we_w = 0;
`ifdef HAZARD_PERF_EN
        perf_clr = 0;
`endif
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        set_idle();
    endtask

    task automatic test_reset();
        rst_n = 0;
        set_idle();
        exp_q.push_back(E_NONE);
        @(negedge clk);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_active: got %h expected %h", obs, exp_v);
        end
        @(posedge clk); #1;
        rst_n = 1;
        exp_q.push_back(E_NONE);
        @(negedge clk);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_release: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_forwarding();
        logic [REG_AW-1:0] r, r2;
        for (int k = 0; k < 4; k++) begin
            r  = REG_AW'($urandom_range(1, 31));
            r2 = REG_AW'((r % 31) + 1);
            next_cycle();
            case (k)
                0: begin
                    rs_e = 5; wa_m = 5; we_m = 1; wa_w = 5; we_w = 1;
                    exp_q.push_back(E_FAE_M);
                end
                1: begin
                    rs_e = 0; wa_m = 0; we_m = 1; wa_w = 0; we_w = 1;
                    exp_q.push_back(E_NONE);
                end
                2: begin
                    rt_e = r; wa_w = r; we_w = 1; wa_m = r2; we_m = 1;
                    exp_q.push_back(E_FBE_W);
                end
                default: begin
                    rs_d = r; rt_d = r2; wa_m = r; we_m = 1;
                    exp_q.push_back(E_FAD);
                end
            endcase
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL fwd[%0d] r=%0d: got %h expected %h", k, r, obs, exp_v);
            end
        end
    endtask

    task automatic test_load_use();
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            if (k == 0) begin
                load_e = 1; we_e = 1; wa_e = 8; rt_d = 8;
                exp_q.push_back(E_HZ);
            end else begin
                load_m = 1; we_m = 1; wa_m = 8; dmem_ready = 1; rt_e = 8;
                exp_q.push_back(E_FBE_M);
            end
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL load_use[%0d]: got %h expected %h", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_branch();
        logic [REG_AW-1:0] r;
        r = REG_AW'($urandom_range(1, 31));
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            case (k)
                0: begin
                    branch_d = 1; rs_d = r; we_e = 1; wa_e = r;
                    exp_q.push_back(E_HZ);
                end
                1: begin
                    branch_d = 1; rt_d = r; load_m = 1; dmem_ready = 1; wa_m = r; we_m = 1;
                    exp_q.push_back(E_HZ | E_FBD);
                end
                2: begin
                    branch_d = 1; rs_d = 0; wa_e = 0; we_e = 1; predict_miss = 1;
                    exp_q.push_back(E_FL_D | E_FL_E);
                end
                default: begin
                    jump_r_d = 1; rs_d = r; wa_e = REG_AW'((r % 31) + 1); we_e = 1;
                    exp_q.push_back(E_FL_D);
                end
            endcase
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL branch[%0d] r=%0d: got %h expected %h", k, r, obs, exp_v);
            end
        end
    endtask

    task automatic test_mdu_div_mfhi();
        for (int c = 0; c < 34; c++) begin
            next_cycle();
            mdu_start_e = (c == 0);
            mdu_div_e   = (c == 0);
            mdu_use_d   = 1;
            if (c == 0)       exp_q.push_back(E_HZ);
            else if (c <= 32) exp_q.push_back(E_HZ | E_BUSY);
            else              exp_q.push_back(E_NONE);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL mdu_div t+%0d: got %h expected %h", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_mdu_mult_restart();
        // plain multiply: busy t+1..t+4
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            mdu_start_e = (c == 0);
            exp_q.push_back((c >= 1 && c <= 4) ? E_BUSY : E_NONE);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL mdu_mult t+%0d: got %h expected %h", c, obs, exp_v);
            end
        end
        // multiply then divide one cycle later reloads: busy through t+33
        for (int c = 0; c < 35; c++) begin
            next_cycle();
            mdu_start_e = (c <= 1);
            mdu_div_e   = (c == 1);
            exp_q.push_back((c >= 1 && c <= 33) ? E_BUSY : E_NONE);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL mdu_restart t+%0d: got %h expected %h", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_mem_wait();
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            if (c < 4) begin
                load_m = 1; we_m = 1; wa_m = 9; predict_miss = 1;
            end
            if (c < 3) begin
                dmem_ready = 0;
                // lower-priority hazards and an MDU issue are held off
                load_e = 1; wa_e = 8; rt_d = 8; mdu_start_e = 1;
                exp_q.push_back(E_MEM);
            end else if (c == 3) begin
                exp_q.push_back(E_FL_D | E_FL_E);
            end else begin
                exp_q.push_back(E_NONE);
            end
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL mem_wait[%0d]: got %h expected %h", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_div();
        for (int c = 0; c <= 10; c++) begin
            next_cycle();
            mdu_start_e = (c == 0);
            mdu_div_e   = (c == 0);
            exp_q.push_back((c >= 1) ? E_BUSY : E_NONE);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL rst_div t+%0d: got %h expected %h", c, obs, exp_v);
            end
        end
        #1;
        rst_n = 0;
        exp_q.push_back(E_NONE);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL rst_div_async: got %h expected %h", obs, exp_v);
        end
        next_cycle();
        rst_n = 1;
        for (int c = 0; c < 2; c++) begin
            if (c > 0) next_cycle();
            mdu_use_d = 1;
            exp_q.push_back(E_NONE);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL rst_div_after[%0d]: got %h expected %h", c, obs, exp_v);
            end
        end
    endtask

`ifdef HAZARD_PERF_EN
    logic [3*PERF_W-1:0] perf_q[$];
    logic [3*PERF_W-1:0] perf_exp;

    task automatic test_perf();
        next_cycle();
        perf_clr = 1;
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            load_m = 1; dmem_ready = 0;
        end
        next_cycle();
        load_e = 1; wa_e = 8; rt_d = 8;
        next_cycle();
        predict_miss = 1;
        next_cycle();
        perf_q.push_back({PERF_W'(5), PERF_W'(4), PERF_W'(1)});
        @(negedge clk);
        perf_exp = perf_q.pop_front();
        checks++;
        if ({perf_stall, perf_memwait, perf_flush} !== perf_exp) begin
            errors++;
            $display("FAIL perf_counts: got %0d/%0d/%0d expected %0d/%0d/%0d",
                     perf_stall, perf_memwait, perf_flush,
                     perf_exp[3*PERF_W-1:2*PERF_W], perf_exp[2*PERF_W-1:PERF_W],
                     perf_exp[PERF_W-1:0]);
        end
        perf_clr = 1;
        next_cycle();
        perf_q.push_back('0);
        @(negedge clk);
        perf_exp = perf_q.pop_front();
        checks++;
        if ({perf_stall, perf_memwait, perf_flush} !== perf_exp) begin
            errors++;
            $display("FAIL perf_clr: got %0d/%0d/%0d expected 0/0/0",
                     perf_stall, perf_memwait, perf_flush);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_mdu_div_mfhi();
        test_mdu_mult_restart();
        test_mem_wait();
        test_reset_mid_div();
`ifdef HAZARD_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
